// File: rtl/ram_arb_pkg.sv
// Shared types and encodings for the program/data RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic PORT_I   = 1'b0;
    localparam logic PORT_D   = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between fetch and data requests.
// RAM_ARB_ROUND_ROBIN_EN: ties alternate; otherwise the data port wins ties.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic ireq,
    input  logic dreq,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        // With no request the result is unused; mirroring last_grant keeps it stable.
        grant = last_grant;
        if (ireq && dreq) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = PORT_D;
`endif
        end else if (dreq) begin
            grant = PORT_D;
        end else if (ireq) begin
            grant = PORT_I;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch and data load/store.
// Tie-break policy selected by RAM_ARB_ROUND_ROBIN_EN (see ram_arb_pick).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IAck,
    output logic [DATA_W-1:0] IData,
    input  logic              DReq,
    input  logic              DWr,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic              DAck,
    output logic [DATA_W-1:0] DRData,
    output logic              RamEnable,
    output logic              RamRW,
    output logic [ADDR_W-1:0] RamAddress,
    output logic [DATA_W-1:0] RamIn,
    input  logic [DATA_W-1:0] RamOut,
    output logic              Busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] wait_cnt;
    logic       cur_port;
    logic       last_grant;
    logic       grant;
    logic       any_req;

    assign any_req = IReq | DReq;

    ram_arb_pick u_pick (
        .ireq       (IReq),
        .dreq       (DReq),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req) state_n = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            IAck       <= 1'b0;
            DAck       <= 1'b0;
            Busy       <= 1'b0;
            RamEnable  <= 1'b0;
            RamRW      <= RW_READ;
            RamAddress <= '0;
            RamIn      <= '0;
            IData      <= '0;
            DRData     <= '0;
            wait_cnt   <= '0;
            cur_port   <= PORT_D;
            last_grant <= PORT_D;
        end else begin
            IAck <= 1'b0;
            DAck <= 1'b0;
            Busy <= (state_n != IDLE);
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_port   <= grant;
                        last_grant <= grant;
                        RamEnable  <= 1'b1;
                        wait_cnt   <= WAIT_INIT;
                        if (grant == PORT_D) begin
                            RamAddress <= DAddr;
                            RamIn      <= DWData;
                            RamRW      <= ~DWr;
                        end else begin
                            RamAddress <= IAddr;
                            RamRW      <= RW_READ;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        RamEnable <= 1'b0;
                        RamRW     <= RW_READ;
                        // Stores leave both read registers untouched.
                        if (RamRW == RW_READ) begin
                            if (cur_port == PORT_D) DRData <= RamOut;
                            else                    IData  <= RamOut;
                        end
                        IAck <= (cur_port == PORT_I);
                        DAck <= (cur_port == PORT_D);
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
